// File: rtl/microcode_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// microcode_sequencer
//
// Programmable controller for the cumulative-adder datapath (8-entry register
// file, 3-bit-op ALU, output buffer, a>b comparator). It fetches 16-bit
// microinstructions from an external synchronous ROM and turns each one into
// a single-cycle datapath control word. Branches test the comparator output.
// Each instruction takes two cycles: FETCH presents the address, EXEC decodes
// the ROM data that arrives one cycle later.
//
// Optional build macro:
//   SEQ_SINGLE_STEP_EN - adds the `step` input and a PAUSE state entered after
//                        every non-HALT EXEC; PAUSE moves on to FETCH only on
//                        a cycle where step=1.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             level; begins execution at pc=0 from IDLE or HALT
//   step              (SEQ_SINGLE_STEP_EN only) releases PAUSE
//   imem_addr         ROM address, always equal to pc
//   imem_data         ROM data, valid the cycle after imem_addr
//   RFSrcMuxSel       1 = RF write data is the constant 1
//   readAddr1/2       RF read ports, also comparator operands a/b
//   writeAddr/writeEn RF write port
//   outBuf            latch RF port-1 data into the output buffer
//   aluOP             ALU opcode (000 add,001 sub,010 and,011 or,100 xor,101 not)
//   aBTb              comparator result RF[readAddr1] > RF[readAddr2]
//   busy              high in FETCH, EXEC (and PAUSE)
//   done              high in HALT
//   state_dbg         current FSM state encoding, for observation only
//
// Handshake: there is no valid/ready pair; the control word is meaningful
// only in the single EXEC cycle and is all-zero in every other state.
// -----------------------------------------------------------------------------
module microcode_sequencer #(
   parameter int PC_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic            step,
`endif
   output logic [PC_W-1:0] imem_addr,
   input  logic [15:0]     imem_data,
   output logic            RFSrcMuxSel,
   output logic [2:0]      readAddr1,
   output logic [2:0]      readAddr2,
   output logic [2:0]      writeAddr,
   output logic            writeEn,
   output logic            outBuf,
   output logic [2:0]      aluOP,
   input  logic            aBTb,
   output logic            busy,
   output logic            done,
   output logic [2:0]      state_dbg
);

   // S_PAUSE keeps its encoding in every build so state_dbg decodes the same
   // way; it is only reachable when single-step is compiled in.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_HALT  = 3'd3,
      S_PAUSE = 3'd4
   } state_t;

   localparam logic [2:0] OP_ALU  = 3'b000;
   localparam logic [2:0] OP_LD1  = 3'b001;
   localparam logic [2:0] OP_OUT  = 3'b010;
   localparam logic [2:0] OP_BRT  = 3'b011;
   localparam logic [2:0] OP_JMP  = 3'b100;
   localparam logic [2:0] OP_HALT = 3'b111;

   state_t          state, state_next;
   logic [PC_W-1:0] pc, pc_next;

   // Instruction fields; bit 12 carries no meaning.
   logic [2:0]      op, f1, f2, f3, f4;
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] pc_inc;
   logic            unused_bit12;
   state_t          after_exec;

   assign op           = imem_data[15:13];
   assign f1           = imem_data[11:9];
   assign f2           = imem_data[8:6];
   assign f3           = imem_data[5:3];
   assign f4           = imem_data[2:0];
   assign target       = imem_data[PC_W-1:0];
   assign unused_bit12 = imem_data[12];
   // Natural PC_W-bit overflow gives the required wrap from the top address to 0.
   assign pc_inc       = pc + {{(PC_W-1){1'b0}}, 1'b1};

`ifdef SEQ_SINGLE_STEP_EN
   assign after_exec = S_PAUSE;
`else
   assign after_exec = S_FETCH;
`endif

   assign imem_addr = pc;
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         pc    <= '0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
      end
   end

   always_comb begin
      state_next  = state;
      pc_next     = pc;
      busy        = 1'b0;
      done        = 1'b0;
      RFSrcMuxSel = 1'b0;
      readAddr1   = 3'd0;
      readAddr2   = 3'd0;
      writeAddr   = 3'd0;
      writeEn     = 1'b0;
      outBuf      = 1'b0;
      aluOP       = 3'd0;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_next = S_FETCH;
               pc_next    = '0;
            end
         end

         S_FETCH: begin
            busy       = 1'b1;
            state_next = S_EXEC;
         end

         S_EXEC: begin
            busy       = 1'b1;
            pc_next    = pc_inc;
            state_next = after_exec;
            case (op)
               OP_ALU: begin
                  writeAddr = f1;
                  readAddr1 = f2;
                  readAddr2 = f3;
                  aluOP     = f4;
                  writeEn   = 1'b1;
               end
               OP_LD1: begin
                  writeAddr   = f1;
                  RFSrcMuxSel = 1'b1;
                  writeEn     = 1'b1;
               end
               OP_OUT: begin
                  readAddr1 = f2;
                  outBuf    = 1'b1;
               end
               OP_BRT: begin
                  // Comparator operands and aBTb are both live in this cycle.
                  readAddr1 = f1;
                  readAddr2 = f2;
                  if (aBTb) pc_next = target;
               end
               OP_JMP: begin
                  pc_next = target;
               end
               OP_HALT: begin
                  pc_next    = pc;
                  state_next = S_HALT;
               end
               default: begin
                  // 101 and 110 are NOPs: advance pc, assert nothing.
               end
            endcase
         end

         S_HALT: begin
            done = 1'b1;
            if (start) begin
               state_next = S_FETCH;
               pc_next    = '0;
            end
         end

`ifdef SEQ_SINGLE_STEP_EN
         S_PAUSE: begin
            busy = 1'b1;
            if (step) state_next = S_FETCH;
         end
`endif

         default: begin
            state_next = S_IDLE;
            pc_next    = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_microcode_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_microcode_sequencer
//
// Bench for microcode_sequencer. The bench provides the ROM (synchronous) and
// a small register-file/ALU/comparator datapath driven by the DUT's control
// word, so aBTb reflects what the DUT actually wrote. An instruction-level
// reference model executes each program from the ROM image with its own
// register file and produces the expected per-cycle output trace; a monitor
// compares that trace against the DUT whenever it is busy or enters HALT.
// -----------------------------------------------------------------------------
module tb_microcode_sequencer;

   localparam int PC_W  = 6;
   localparam int DEPTH = 1 << PC_W;
   localparam int EW    = PC_W + 17;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   logic            start = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
   logic            step = 1'b1;
`endif
   logic [PC_W-1:0] imem_addr;
   logic [15:0]     imem_data;
   logic            RFSrcMuxSel, writeEn, outBuf, aBTb, busy, done;
   logic [2:0]      readAddr1, readAddr2, writeAddr, aluOP, state_dbg;

   microcode_sequencer #(.PC_W(PC_W)) dut (
      .clk(clk), .reset(reset), .start(start),
`ifdef SEQ_SINGLE_STEP_EN
      .step(step),
`endif
      .imem_addr(imem_addr), .imem_data(imem_data),
      .RFSrcMuxSel(RFSrcMuxSel), .readAddr1(readAddr1), .readAddr2(readAddr2),
      .writeAddr(writeAddr), .writeEn(writeEn), .outBuf(outBuf), .aluOP(aluOP),
      .aBTb(aBTb), .busy(busy), .done(done), .state_dbg(state_dbg)
   );

   // ---------------- environment: ROM + datapath ----------------
   logic [15:0] rom [DEPTH];
   logic [7:0]  dp_rf [8];
   logic [7:0]  dp_out;
   logic        clear_rf = 1'b0;

   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return ~a;
         default: return 8'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      imem_data <= rom[imem_addr];
      if (clear_rf) begin
         for (int i = 0; i < 8; i++) dp_rf[i] <= 8'd0;
         dp_out <= 8'd0;
      end else begin
         if (writeEn)
            dp_rf[writeAddr] <= RFSrcMuxSel ? 8'd1
                               : alu_f(dp_rf[readAddr1], dp_rf[readAddr2], aluOP);
         if (outBuf) dp_out <= dp_rf[readAddr1];
      end
   end

   assign aBTb = dp_rf[readAddr1] > dp_rf[readAddr2];

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   int            checks = 0;
   int            failures = 0;
   logic          mon_en = 1'b0;
   logic [7:0]    m_rf [8];
   logic [7:0]    m_out;

   function automatic logic [EW-1:0] mk(input logic [PC_W-1:0] a, input logic src,
      input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] wa,
      input logic we, input logic ob, input logic [2:0] alu, input logic b,
      input logic d);
      return {a, src, r1, r2, wa, we, ob, alu, b, d};
   endfunction

   function automatic logic [EW-1:0] actual();
      return {imem_addr, RFSrcMuxSel, readAddr1, readAddr2, writeAddr,
              writeEn, outBuf, aluOP, busy, done};
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Executes the ROM at instruction level and emits the expected outputs of
   // every FETCH / EXEC (/ PAUSE) cycle plus the first HALT cycle.
   task automatic model_run(input int runs);
      logic [PC_W-1:0] pc;
      logic [15:0]     ins;
      logic [2:0]      op, f1, f2, f3, f4;
      bit              halted;
      for (int r = 0; r < runs; r++) begin
         pc = '0;
         halted = 1'b0;
         for (int k = 0; k < 400 && !halted; k++) begin
            ins = rom[pc];
            op = ins[15:13]; f1 = ins[11:9]; f2 = ins[8:6]; f3 = ins[5:3]; f4 = ins[2:0];
            exp_q.push_back(mk(pc, 0, 0, 0, 0, 0, 0, 0, 1, 0));
            case (op)
               3'b000: begin
                  exp_q.push_back(mk(pc, 0, f2, f3, f1, 1, 0, f4, 1, 0));
                  m_rf[f1] = alu_f(m_rf[f2], m_rf[f3], f4);
                  pc = pc + 1'b1;
               end
               3'b001: begin
                  exp_q.push_back(mk(pc, 1, 0, 0, f1, 1, 0, 0, 1, 0));
                  m_rf[f1] = 8'd1;
                  pc = pc + 1'b1;
               end
               3'b010: begin
                  exp_q.push_back(mk(pc, 0, f2, 0, 0, 0, 1, 0, 1, 0));
                  m_out = m_rf[f2];
                  pc = pc + 1'b1;
               end
               3'b011: begin
                  exp_q.push_back(mk(pc, 0, f1, f2, 0, 0, 0, 0, 1, 0));
                  pc = (m_rf[f1] > m_rf[f2]) ? ins[PC_W-1:0] : pc + 1'b1;
               end
               3'b100: begin
                  exp_q.push_back(mk(pc, 0, 0, 0, 0, 0, 0, 0, 1, 0));
                  pc = ins[PC_W-1:0];
               end
               3'b111: begin
                  exp_q.push_back(mk(pc, 0, 0, 0, 0, 0, 0, 0, 1, 0));
                  exp_q.push_back(mk(pc, 0, 0, 0, 0, 0, 0, 0, 0, 1));
                  halted = 1'b1;
               end
               default: begin
                  exp_q.push_back(mk(pc, 0, 0, 0, 0, 0, 0, 0, 1, 0));
                  pc = pc + 1'b1;
               end
            endcase
`ifdef SEQ_SINGLE_STEP_EN
            if (!halted) exp_q.push_back(mk(pc, 0, 0, 0, 0, 0, 0, 0, 1, 0));
`endif
         end
      end
   endtask

   // ---------------- monitor ----------------
   task automatic monitor_loop();
      logic          done_prev = 1'b0;
      logic [EW-1:0] e;
      forever begin
         @(negedge clk);
         if (mon_en && (busy || (done && !done_prev))) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", {{(32-EW){1'b0}}, actual()}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("trace", {{(32-EW){1'b0}}, actual()}, {{(32-EW){1'b0}}, e});
            end
         end
         done_prev = done;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_all();
      clear_rf = 1'b1;
      @(posedge clk); #1;
      clear_rf = 1'b0;
      for (int i = 0; i < 8; i++) m_rf[i] = 8'd0;
      m_out = 8'd0;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < DEPTH; i++) rom[i] = 16'hE000;
   endtask

   // Runs the loaded program `runs` times. With hold=1 start stays high so
   // HALT restarts immediately, dropped once the final HALT is reached.
   task automatic run_prog(input string name, input int runs, input bit hold);
      int cyc = 0;
      int dones = 0;
      clear_all();
      model_run(runs);
      mon_en = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      while (exp_q.size() != 0 && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
         if (hold && done) begin
            dones++;
            if (dones >= runs) start = 1'b0;
         end
      end
      start = 1'b0;
      if (cyc >= 3000) begin
         chk({name, "_timeout"}, exp_q.size(), 0);
         exp_q.delete();
      end
      @(posedge clk); #1;
      mon_en = 1'b0;
      chk({name, "_done"}, {31'd0, done}, 1);
      chk({name, "_outbuf"}, {24'd0, dp_out}, {24'd0, m_out});
      for (int i = 0; i < 8; i++)
         chk({name, "_rf"}, {24'd0, dp_rf[i]}, {24'd0, m_rf[i]});
   endtask

   task automatic gen_random(input int len);
      logic [2:0]  op;
      logic [15:0] ins;
      clear_rom();
      for (int p = 0; p < len - 1; p++) begin
         op  = 3'($urandom_range(0, 6));
         ins = {op, 13'($urandom)};
         if (op == 3'b011 || op == 3'b100)
            ins[5:0] = 6'($urandom_range(p + 1, len - 1));
         rom[p] = ins;
      end
      rom[len - 1] = {3'b111, 13'($urandom)};
   endtask

   // ---------------- main sequence ----------------
   initial begin
      fork
         monitor_loop();
      join_none

      clear_rom();
      repeat (3) @(posedge clk);
      #1;
      chk("in_reset_idle", {{(32-EW){1'b0}}, actual()}, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("idle_no_start", {{(32-EW){1'b0}}, actual()}, 32'd0);
      end

      // LD1 R1; R4 = R1 + R1; OUT R4; HALT.
      rom[0] = 16'h2200; rom[1] = 16'h0848; rom[2] = 16'h4100; rom[3] = 16'hE000;
      run_prog("basic", 1, 1'b0);

      // Same program, start held in HALT: immediate restart from pc=0.
      run_prog("restart", 2, 1'b1);

      // BRT taken: R1=1 > R2=0, pc2 branches to 5.
      clear_rom();
      rom[0] = 16'h2200; rom[1] = 16'hA000; rom[2] = 16'h6285;
      rom[3] = 16'hE000; rom[5] = 16'hE000;
      run_prog("brt_taken", 1, 1'b0);

      // BRT not taken: R1=0, R2=1, falls through to 3.
      rom[0] = 16'h2400;
      run_prog("brt_fall", 1, 1'b0);

      // JMP 63, NOP at 63 wraps to 0; second pass branches to HALT at 3.
      clear_rom();
      rom[0] = 16'h6283; rom[1] = 16'h2200; rom[2] = 16'h803F;
      rom[3] = 16'hE000; rom[63] = 16'hA000;
      run_prog("jmp_wrap", 1, 1'b0);

      for (int t = 0; t < 8; t++) begin
         gen_random($urandom_range(6, 20));
         run_prog("random", 1, 1'b0);
      end

      // Reset during EXEC of an ALU instruction.
      clear_rom();
      rom[0] = 16'h2200; rom[1] = 16'h0848; rom[2] = 16'hE000;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      begin
         int cyc = 0;
         while (!(writeEn && !RFSrcMuxSel) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
         end
         chk("rst_reach_alu_exec", {31'd0, writeEn & ~RFSrcMuxSel}, 1);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_exec_outputs", {{(32-EW){1'b0}}, actual()}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_exec_stays_idle", {{(32-EW){1'b0}}, actual()}, 32'd0);
      run_prog("after_reset", 1, 1'b0);

`ifdef SEQ_SINGLE_STEP_EN
      // Three LD1s then HALT; step low parks the sequencer in PAUSE.
      clear_rom();
      rom[0] = 16'h2200; rom[1] = 16'h2400; rom[2] = 16'h2600; rom[3] = 16'hE000;
      step = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("step_exec0", {{(32-EW){1'b0}}, actual()},
          {{(32-EW){1'b0}}, mk(0, 1, 0, 0, 1, 1, 0, 0, 1, 0)});
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("step_pause_hold", {{(32-EW){1'b0}}, actual()},
             {{(32-EW){1'b0}}, mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
      end
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      @(posedge clk); #1;
      chk("step_exec1", {{(32-EW){1'b0}}, actual()},
          {{(32-EW){1'b0}}, mk(1, 1, 0, 0, 2, 1, 0, 0, 1, 0)});
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("step_pause_again", {{(32-EW){1'b0}}, actual()},
             {{(32-EW){1'b0}}, mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
      end
      step = 1'b1;
      begin
         int cyc = 0;
         while (!done && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
         end
         chk("step_finish", {31'd0, done}, 1);
      end
`endif

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
